// File: rtl/traffic_sensor_conditioner.sv
// Vehicle-detector conditioning for the traffic light controller: per street a
// 2-flop synchronizer, on-debounce, off-hold gap bridging and a saturating arrival counter.

module traffic_sensor_channel #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw,
  input  logic             cnt_clr,
  output logic             sens,
  output logic             arr,
  output logic [CNT_W-1:0] cnt
);

  localparam int MAX_C = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
  localparam int QW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [QW-1:0] DEB_LAST  = QW'(DEB_CYCLES - 1);
  localparam logic [QW-1:0] HOLD_LAST = QW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, QUAL_ON, ACTIVE, QUAL_OFF} state_t;

  logic          sync_p0, sync_p1;
  state_t        state, state_nxt;
  logic [QW-1:0] q, q_nxt;
  logic          sens_nxt, arr_nxt;

  // Stage p0/p1: synchronizer for the asynchronous detector input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    case (state)
      IDLE: begin
        if (sync_p1) begin
          state_nxt = QUAL_ON;
          q_nxt     = '0;
        end
      end
      QUAL_ON: begin
        if (!sync_p1) begin
          state_nxt = IDLE;
          q_nxt     = '0;
        end else if (q == DEB_LAST) begin
          state_nxt = ACTIVE;
          q_nxt     = '0;
        end else begin
          q_nxt = q + 1'b1;
        end
      end
      ACTIVE: begin
        if (!sync_p1) begin
          state_nxt = QUAL_OFF;
          q_nxt     = '0;
        end
      end
      QUAL_OFF: begin
        // A return to high inside the hold window is the same vehicle, not a new arrival
        if (sync_p1) begin
          state_nxt = ACTIVE;
          q_nxt     = '0;
        end else if (q == HOLD_LAST) begin
          state_nxt = IDLE;
          q_nxt     = '0;
        end else begin
          q_nxt = q + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        q_nxt     = '0;
      end
    endcase
    sens_nxt = (state_nxt == ACTIVE) || (state_nxt == QUAL_OFF);
    arr_nxt  = (state == QUAL_ON) && (state_nxt == ACTIVE);
  end

  // Stage p2: qualification state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= '0;
      sens  <= 1'b0;
      arr   <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      sens  <= sens_nxt;
      arr   <= arr_nxt;
    end
  end

  // Counter follows the arrival pulse; a clear coinciding with a pulse keeps that arrival
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= arr ? CNT_W'(1) : '0;
    end else if (arr && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

module traffic_sensor_conditioner #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Sa_raw_i,
  input  logic             Sb_raw_i,
  input  logic             cnt_clr_i,
  output logic             Sa_o,
  output logic             Sb_o,
  output logic             arr_a_o,
  output logic             arr_b_o,
  output logic [CNT_W-1:0] cnt_a_o,
  output logic [CNT_W-1:0] cnt_b_o
);

  traffic_sensor_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_chan_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (Sa_raw_i),
    .cnt_clr(cnt_clr_i),
    .sens   (Sa_o),
    .arr    (arr_a_o),
    .cnt    (cnt_a_o)
  );

  traffic_sensor_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_chan_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (Sb_raw_i),
    .cnt_clr(cnt_clr_i),
    .sens   (Sb_o),
    .arr    (arr_b_o),
    .cnt    (cnt_b_o)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner (DEB_CYCLES=4, HOLD_CYCLES=8, CNT_W=8).

module tb_traffic_sensor_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Sa_raw_i, Sb_raw_i, cnt_clr_i;
  logic       Sa_o, Sb_o, arr_a_o, arr_b_o;
  logic [7:0] cnt_a_o, cnt_b_o;

  int n_vec  = 0;
  int n_miss = 0;

  traffic_sensor_conditioner #(
    .DEB_CYCLES (4),
    .HOLD_CYCLES(8),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Sa_raw_i (Sa_raw_i),
    .Sb_raw_i (Sb_raw_i),
    .cnt_clr_i(cnt_clr_i),
    .Sa_o     (Sa_o),
    .Sb_o     (Sb_o),
    .arr_a_o  (arr_a_o),
    .arr_b_o  (arr_b_o),
    .cnt_a_o  (cnt_a_o),
    .cnt_b_o  (cnt_b_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       raw_a;
    bit       raw_b;
    bit       exp_sa;
    bit       exp_sb;
    bit       exp_arr_a;
    bit       exp_arr_b;
    int       exp_cnt_a;
    int       exp_cnt_b;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " Sa_o"}, int'(Sa_o), 0);
    check({tag, " Sb_o"}, int'(Sb_o), 0);
    check({tag, " arr_a_o"}, int'(arr_a_o), 0);
    check({tag, " arr_b_o"}, int'(arr_b_o), 0);
    check({tag, " cnt_a_o"}, int'(cnt_a_o), 0);
    check({tag, " cnt_b_o"}, int'(cnt_b_o), 0);
  endtask

  // One complete isolated vehicle: 5 synchronized-high cycles qualify, 12 low cycles return to IDLE
  task automatic arrive(input bit on_a, input bit on_b);
    Sa_raw_i = on_a;
    Sb_raw_i = on_b;
    repeat (6) step();
    Sa_raw_i = 1'b0;
    Sb_raw_i = 1'b0;
    repeat (12) step();
  endtask

  initial begin
    // Vector v is sampled at edge v; the channel FSM reacts to raw(v-2).
    // A: high 1..10 -> QUAL_ON@3, ACTIVE@7, QUAL_OFF@13, IDLE@21.
    // B: high 3..6 (one short), low 7, high 8..12 -> IDLE@9, QUAL_ON@10, ACTIVE@14, QUAL_OFF@15, IDLE@23.
    for (int v = 1; v <= NV; v++) begin
      vecs[v-1].raw_a     = (v <= 10);
      vecs[v-1].raw_b     = (v >= 3 && v <= 6) || (v >= 8 && v <= 12);
      vecs[v-1].exp_sa    = (v >= 7 && v <= 20);
      vecs[v-1].exp_arr_a = (v == 7);
      vecs[v-1].exp_cnt_a = (v >= 8) ? 1 : 0;
      vecs[v-1].exp_sb    = (v >= 14 && v <= 22);
      vecs[v-1].exp_arr_b = (v == 14);
      vecs[v-1].exp_cnt_b = (v >= 15) ? 1 : 0;
    end

    rst_n     = 1'b0;
    Sa_raw_i  = 1'b0;
    Sb_raw_i  = 1'b0;
    cnt_clr_i = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check_all_zero("post_reset");

    // Table: clean assert/deassert on A, bounce-then-qualify on B, simultaneously
    for (int i = 0; i < NV; i++) begin
      Sa_raw_i = vecs[i].raw_a;
      Sb_raw_i = vecs[i].raw_b;
      step();
      check($sformatf("vec%0d Sa_o", i + 1), int'(Sa_o), int'(vecs[i].exp_sa));
      check($sformatf("vec%0d Sb_o", i + 1), int'(Sb_o), int'(vecs[i].exp_sb));
      check($sformatf("vec%0d arr_a_o", i + 1), int'(arr_a_o), int'(vecs[i].exp_arr_a));
      check($sformatf("vec%0d arr_b_o", i + 1), int'(arr_b_o), int'(vecs[i].exp_arr_b));
      check($sformatf("vec%0d cnt_a_o", i + 1), int'(cnt_a_o), vecs[i].exp_cnt_a);
      check($sformatf("vec%0d cnt_b_o", i + 1), int'(cnt_b_o), vecs[i].exp_cnt_b);
    end

    // Asynchronous reset while A is active with a count of 5
    repeat (3) arrive(1'b1, 1'b0);
    check("pre_rst cnt_a_o", int'(cnt_a_o), 4);
    Sa_raw_i = 1'b1;
    repeat (8) step();
    check("pre_rst Sa_o", int'(Sa_o), 1);
    check("pre_rst cnt_a_o5", int'(cnt_a_o), 5);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    Sa_raw_i = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("rst_exit%0d Sa_o", i), int'(Sa_o), 0);
    end
    check_all_zero("rst_exit_end");

    // Bounce on A: high 3, low 1, then held high; last rise sampled at edge 5, output up after edge 11
    for (int e = 1; e <= 12; e++) begin
      Sa_raw_i = (e != 4);
      step();
      check($sformatf("bounce%0d Sa_o", e), int'(Sa_o), (e >= 11) ? 1 : 0);
      check($sformatf("bounce%0d arr_a_o", e), int'(arr_a_o), (e == 11) ? 1 : 0);
      check($sformatf("bounce%0d cnt_a_o", e), int'(cnt_a_o), (e == 12) ? 1 : 0);
    end

    // Gap of 5 low cycles while ACTIVE is bridged: no drop, no new arrival
    for (int e = 1; e <= 12; e++) begin
      Sa_raw_i = (e > 5);
      step();
      check($sformatf("gap%0d Sa_o", e), int'(Sa_o), 1);
      check($sformatf("gap%0d arr_a_o", e), int'(arr_a_o), 0);
    end
    check("gap cnt_a_o", int'(cnt_a_o), 1);
    Sa_raw_i = 1'b0;
    repeat (10) step();
    check("gap release Sa_o", int'(Sa_o), 1);
    repeat (2) step();
    check("gap release Sa_o idle", int'(Sa_o), 0);

    // Saturation on B
    for (int i = 0; i < 260; i++) begin
      arrive(1'b0, 1'b1);
      if (i == 253) check("sat254 cnt_b_o", int'(cnt_b_o), 254);
    end
    check("sat cnt_b_o", int'(cnt_b_o), 255);
    check("sat cnt_a_o", int'(cnt_a_o), 1);

    // Clear in the same cycle as an arrival pulse on B
    Sb_raw_i = 1'b1;
    repeat (7) step();
    check("clr arr_b_o", int'(arr_b_o), 1);
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    check("clr cnt_b_o", int'(cnt_b_o), 1);
    check("clr cnt_a_o", int'(cnt_a_o), 0);
    check("clr Sb_o", int'(Sb_o), 1);
    Sb_raw_i = 1'b0;
    repeat (14) step();
    check("clr end Sb_o", int'(Sb_o), 0);
    check("clr end cnt_b_o", int'(cnt_b_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
